// File: rtl/contador_modulo_n_updown.sv
// contador_modulo_n_updown
// Parametrised modulo-N up/down counter with count enable, synchronous
// parallel load with range checking, combinational terminal count for
// cascading, a registered wrap pulse and a sticky load-error flag.
module contador_modulo_n_updown #(
   parameter int WIDTH       = 4,
   parameter int MODULUS     = 9,
   parameter int RESET_VALUE = 0
) (
   input  logic             clk_input,
   input  logic             clear_input,
   input  logic             enable_input,
   input  logic             up_input,
   input  logic             load_input,
   input  logic [WIDTH-1:0] load_value_input,
   output logic [WIDTH-1:0] contador_output,
   output logic             terminal_output,
   output logic             wrap_output,
   output logic             load_error_output
);

   // Reject parameter sets that would let the register hold values outside
   // the count range or make the reset value unreachable.
   generate
      if ((MODULUS < 2) || (WIDTH < 1) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
         $error("contador_modulo_n_updown: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
      end
      if ((RESET_VALUE < 0) || (RESET_VALUE >= MODULUS)) begin : g_bad_reset_value
         $error("contador_modulo_n_updown: RESET_VALUE must be below MODULUS");
      end
   endgenerate

   // Top of the count range, the reset value, and the modulus widened by one
   // bit so MODULUS = 2**WIDTH is still representable for the load compare.
   localparam logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH:0]   MODULUS_EXT = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] count_q;
   logic             wrap_q;
   logic             load_error_q;
   logic             load_in_range;
   logic             at_max;
   logic             at_zero;

   assign load_in_range = ({1'b0, load_value_input} < MODULUS_EXT);
   assign at_max        = (count_q == MAX_COUNT);
   assign at_zero       = (count_q == '0);

   // Terminal count looks at the current state and this cycle's request, so a
   // following stage sees it on the same edge that makes this stage wrap.
   assign terminal_output = enable_input & ~load_input &
                            ((up_input & at_max) | (~up_input & at_zero));

   // Counter state: load beats count beats hold; wrapping is done explicitly
   // so the register never passes through a value at or above MODULUS.
   always_ff @(posedge clk_input or negedge clear_input) begin
      if (!clear_input) begin
         count_q      <= RESET_COUNT;
         wrap_q       <= 1'b0;
         load_error_q <= 1'b0;
      end else if (load_input) begin
         wrap_q <= 1'b0;
         if (load_in_range) begin
            count_q <= load_value_input;
         end else begin
            count_q      <= '0;
            load_error_q <= 1'b1;
         end
      end else if (enable_input) begin
         if (up_input) begin
            if (at_max) begin
               count_q <= '0;
               wrap_q  <= 1'b1;
            end else begin
               count_q <= count_q + WIDTH'(1);
               wrap_q  <= 1'b0;
            end
         end else begin
            if (at_zero) begin
               count_q <= MAX_COUNT;
               wrap_q  <= 1'b1;
            end else begin
               count_q <= count_q - WIDTH'(1);
               wrap_q  <= 1'b0;
            end
         end
      end else begin
         wrap_q <= 1'b0;
      end
   end

   assign contador_output   = count_q;
   assign wrap_output       = wrap_q;
   assign load_error_output = load_error_q;

endmodule

// File: tb/tb_contador_modulo_n_updown.sv
// tb_contador_modulo_n_updown
// Drives a modulo-9 counter from a vector table, a modulo-2 single-bit
// counter for back-to-back wraps, and a two-stage modulo-16 cascade.
module tb_contador_modulo_n_updown;

   typedef struct {
      logic       load;
      logic [3:0] lval;
      logic       en;
      logic       up;
      logic       term;
      logic [3:0] cnt;
      logic       wrap;
      logic       err;
   } vec_t;

   logic clk_input = 1'b0;
   logic clear_n;

   logic       load;
   logic [3:0] lval;
   logic       en;
   logic       up;
   logic [3:0] cnt;
   logic       term;
   logic       wrap;
   logic       err;

   logic       m2_en;
   logic       m2_up;
   logic       m2_load;
   logic [0:0] m2_lval;
   logic [0:0] m2_cnt;
   logic       m2_term;
   logic       m2_wrap;
   logic       m2_err;

   logic       casc_en;
   logic       casc_zero;
   logic [3:0] casc_zero_val;
   logic [3:0] lo_cnt;
   logic       lo_term;
   logic       lo_wrap;
   logic       lo_err;
   logic [3:0] hi_cnt;
   logic       hi_term;
   logic       hi_wrap;
   logic       hi_err;

   int   num_checks = 0;
   int   num_errors = 0;
   vec_t vecs[$];
   vec_t exp_q[$];
   int   side_q[$];
   int   split_idx;
   int   lo_wrap_pulses;

   // Free-running 100 MHz clock.
   always #5 clk_input = ~clk_input;

   contador_modulo_n_updown #(.WIDTH(4), .MODULUS(9), .RESET_VALUE(0)) dut (
      .clk_input        (clk_input),
      .clear_input      (clear_n),
      .enable_input     (en),
      .up_input         (up),
      .load_input       (load),
      .load_value_input (lval),
      .contador_output  (cnt),
      .terminal_output  (term),
      .wrap_output      (wrap),
      .load_error_output(err)
   );

   contador_modulo_n_updown #(.WIDTH(1), .MODULUS(2), .RESET_VALUE(0)) dut_m2 (
      .clk_input        (clk_input),
      .clear_input      (clear_n),
      .enable_input     (m2_en),
      .up_input         (m2_up),
      .load_input       (m2_load),
      .load_value_input (m2_lval),
      .contador_output  (m2_cnt),
      .terminal_output  (m2_term),
      .wrap_output      (m2_wrap),
      .load_error_output(m2_err)
   );

   contador_modulo_n_updown #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut_lo (
      .clk_input        (clk_input),
      .clear_input      (clear_n),
      .enable_input     (casc_en),
      .up_input         (1'b1),
      .load_input       (casc_zero),
      .load_value_input (casc_zero_val),
      .contador_output  (lo_cnt),
      .terminal_output  (lo_term),
      .wrap_output      (lo_wrap),
      .load_error_output(lo_err)
   );

   contador_modulo_n_updown #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut_hi (
      .clk_input        (clk_input),
      .clear_input      (clear_n),
      .enable_input     (lo_term),
      .up_input         (1'b1),
      .load_input       (casc_zero),
      .load_value_input (casc_zero_val),
      .contador_output  (hi_cnt),
      .terminal_output  (hi_term),
      .wrap_output      (hi_wrap),
      .load_error_output(hi_err)
   );

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic addVec(input logic ld, input logic [3:0] lv, input logic e, input logic u,
                         input logic t, input logic [3:0] c, input logic w, input logic er);
      vec_t v;
      v.load = ld; v.lval = lv; v.en = e; v.up = u;
      v.term = t; v.cnt = c; v.wrap = w; v.err = er;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input int idx);
      vec_t v;
      if (exp_q.size() == 0) begin
         checkValue($sformatf("vec%0d scoreboard empty", idx), 32'd1, 32'd0);
      end else begin
         v = exp_q.pop_front();
         checkValue($sformatf("vec%0d count", idx), cnt, v.cnt);
         checkValue($sformatf("vec%0d wrap", idx), wrap, v.wrap);
         checkValue($sformatf("vec%0d load_error", idx), err, v.err);
      end
   endtask

   // Called just after a falling edge; returns just after the next one.
   task automatic applyStimulus(input vec_t v, input int idx);
      load = v.load; lval = v.lval; en = v.en; up = v.up;
      exp_q.push_back(v);
      #1;
      checkValue($sformatf("vec%0d terminal", idx), term, v.term);
      @(posedge clk_input);
      #1;
      checkOutput(idx);
      @(negedge clk_input);
   endtask

   // Hard stop in case anything stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // up count through the 8->0 wrap
      for (int k = 1; k <= 8; k++) addVec(0, 0, 1, 1, 0, 4'(k), 0, 0);
      addVec(0, 0, 1, 1, 1, 0, 1, 0);
      addVec(0, 0, 1, 1, 0, 1, 0, 0);
      // load 2 then count down through the 0->8 wrap
      addVec(1, 2, 0, 0, 0, 2, 0, 0);
      addVec(0, 0, 1, 0, 0, 1, 0, 0);
      addVec(0, 0, 1, 0, 0, 0, 0, 0);
      addVec(0, 0, 1, 0, 1, 8, 1, 0);
      addVec(0, 0, 1, 0, 0, 7, 0, 0);
      // direction change on the very next edge
      addVec(0, 0, 1, 1, 0, 8, 0, 0);
      addVec(0, 0, 1, 0, 0, 7, 0, 0);
      // load beats enable, and masks terminal even at the top value
      addVec(1, 5, 0, 0, 0, 5, 0, 0);
      addVec(1, 3, 1, 1, 0, 3, 0, 0);
      addVec(1, 8, 0, 0, 0, 8, 0, 0);
      addVec(1, 1, 1, 1, 0, 1, 0, 0);
      // out-of-range loads, including exactly MODULUS, then sticky error
      addVec(1, 12, 0, 0, 0, 0, 0, 1);
      addVec(1, 9, 1, 1, 0, 0, 0, 1);
      addVec(1, 4, 0, 0, 0, 4, 0, 1);
      // a load right after a wrap clears the wrap pulse
      addVec(1, 8, 0, 0, 0, 8, 0, 1);
      addVec(0, 0, 1, 1, 1, 0, 1, 1);
      addVec(1, 6, 1, 1, 0, 6, 0, 1);
      // hold at 6 for five edges
      addVec(0, 0, 0, 1, 0, 6, 0, 1);
      addVec(0, 0, 0, 0, 0, 6, 0, 1);
      addVec(0, 0, 0, 1, 0, 6, 0, 1);
      addVec(0, 0, 0, 0, 0, 6, 0, 1);
      addVec(0, 0, 0, 1, 0, 6, 0, 1);
      // count up into a wrap so clear lands while wrap is high
      addVec(0, 0, 1, 1, 0, 7, 0, 1);
      addVec(0, 0, 1, 1, 0, 8, 0, 1);
      addVec(0, 0, 1, 1, 1, 0, 1, 1);
      split_idx = vecs.size();
      // after clear: normal first edge, down wrap, hold drops wrap, worst load
      addVec(0, 0, 1, 1, 0, 1, 0, 0);
      addVec(0, 0, 1, 0, 0, 0, 0, 0);
      addVec(0, 0, 1, 0, 1, 8, 1, 0);
      addVec(0, 0, 0, 0, 0, 8, 0, 0);
      addVec(1, 15, 0, 0, 0, 0, 0, 1);

      clear_n = 1'b0;
      load = 0; lval = 0; en = 0; up = 0;
      m2_en = 0; m2_up = 0; m2_load = 0; m2_lval = 1'b0;
      casc_en = 0; casc_zero = 0; casc_zero_val = 4'd0;
      lo_wrap_pulses = 0;

      #12;
      checkValue("reset count", cnt, 4'd0);
      checkValue("reset wrap", wrap, 1'b0);
      checkValue("reset load_error", err, 1'b0);
      checkValue("reset m2 count", m2_cnt, 1'b0);
      checkValue("reset cascade", {hi_cnt, lo_cnt}, 8'd0);
      clear_n = 1'b1;
      @(negedge clk_input);

      for (int i = 0; i < split_idx; i++) applyStimulus(vecs[i], i);

      // asynchronous clear between edges while wrap and error are both high
      #2;
      clear_n = 1'b0;
      #1;
      checkValue("async clear count", cnt, 4'd0);
      checkValue("async clear wrap", wrap, 1'b0);
      checkValue("async clear load_error", err, 1'b0);
      load = 0; en = 1; up = 1;
      @(posedge clk_input);
      #1;
      checkValue("count frozen under clear", cnt, 4'd0);
      @(negedge clk_input);
      clear_n = 1'b1;

      for (int i = split_idx; i < vecs.size(); i++) applyStimulus(vecs[i], i);
      load = 0; en = 0;

      // modulo-2 with direction chosen so every edge after the first wraps
      for (int i = 0; i < 7; i++) begin
         m2_en = 1'b1;
         m2_up = (i == 0) ? 1'b1 : ((i % 2) == 1);
         side_q.push_back((i == 0) ? 1 : (((i % 2) == 1) ? 2 : 3));
         #1;
         checkValue($sformatf("m2 step%0d terminal", i), m2_term, (i == 0) ? 1'b0 : 1'b1);
         @(posedge clk_input);
         #1;
         if (side_q.size() == 0) begin
            checkValue("m2 scoreboard empty", 32'd1, 32'd0);
         end else begin
            int e;
            e = side_q.pop_front();
            checkValue($sformatf("m2 step%0d count", i), m2_cnt, e[0]);
            checkValue($sformatf("m2 step%0d wrap", i), m2_wrap, e[1]);
         end
         @(negedge clk_input);
      end
      m2_en = 1'b0;

      // two-stage modulo-16 cascade counting 40 edges
      for (int k = 1; k <= 40; k++) begin
         casc_en = 1'b1;
         side_q.push_back(k);
         @(posedge clk_input);
         #1;
         if (lo_wrap) lo_wrap_pulses++;
         if (side_q.size() == 0) begin
            checkValue("cascade scoreboard empty", 32'd1, 32'd0);
         end else begin
            checkValue($sformatf("cascade edge%0d value", k), {hi_cnt, lo_cnt}, side_q.pop_front());
         end
         @(negedge clk_input);
      end
      casc_en = 1'b0;
      checkValue("cascade high stage", hi_cnt, 4'd2);
      checkValue("cascade low stage", lo_cnt, 4'd8);
      checkValue("cascade low wrap pulses", lo_wrap_pulses, 2);
      checkValue("cascade high wrap", hi_wrap, 1'b0);
      checkValue("cascade high terminal", hi_term, 1'b0);
      checkValue("cascade load errors", {hi_err, lo_err}, 2'b00);
      checkValue("m2 load_error", m2_err, 1'b0);

      $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
      $finish;
   end

endmodule

// File: doc/contador_modulo_n_updown.md
Name: contador_modulo_n_updown

Overview:
- Parametrised modulo-N synchronous counter; successor of the fixed modulo-9 up counter.
- Adds up/down direction, count enable, synchronous parallel load with range checking, and a combinational terminal-count output for cascading stages.
- Registered wrap pulse and a sticky load-error flag are provided.
- Used as the general counting primitive in timing/sequencing blocks; multiple instances cascade through terminal_output into the next stage's enable_input.

Parameters:
- WIDTH, 4, counter register width in bits.
- MODULUS, 9, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration fails otherwise.
- RESET_VALUE, 0, value loaded by clear_input. Must be < MODULUS.

Ports:
- clk_input  input  1  clock, rising edge active
- clear_input  input  1  asynchronous, active-low reset
- enable_input  input  1  count enable; 1 = count this edge
- up_input  input  1  direction; 1 = up, 0 = down
- load_input  input  1  synchronous parallel load request
- load_value_input  input  WIDTH  value to load
- contador_output  output  WIDTH  current count
- terminal_output  output  1  combinational terminal count, for cascade
- wrap_output  output  1  registered one-cycle pulse after a wrap
- load_error_output  output  1  sticky flag, out-of-range load seen

Behaviour:
- Reset: clear_input low asynchronously forces contador_output=RESET_VALUE, wrap_output=0, load_error_output=0, regardless of clock. All are held while low. The first active edge after release operates normally.
- Priority at each rising edge: load_input, then enable_input, then hold.
- Load in range (load_value_input < MODULUS): contador_output <= load_value_input. wrap_output <= 0. enable_input is ignored that cycle.
- Load out of range (load_value_input >= MODULUS): contador_output <= 0. load_error_output <= 1. wrap_output <= 0.
- Count up (enable_input=1, up_input=1): count < MODULUS-1 -> count+1. Count = MODULUS-1 -> 0, and wrap_output <= 1.
- Count down (enable_input=1, up_input=0): count > 0 -> count-1. Count = 0 -> MODULUS-1, and wrap_output <= 1.
- Hold (enable_input=0, no load): count unchanged, wrap_output <= 0.
- wrap_output: high exactly one cycle, the cycle following the wrapping edge. Back-to-back wraps (MODULUS=2, continuous enable) keep it high on consecutive cycles.
- terminal_output = enable_input & ~load_input & ((up_input & count==MODULUS-1) | (~up_input & count==0)). Purely combinational, zero latency. Used as the next stage's enable_input for a synchronous cascade.
- load_error_output: once set, stays 1 until clear_input is asserted. A later valid load does not clear it.
- Direction change mid-count takes effect on the same edge; no extra latency and no skipped values.
- Arithmetic: modulo MODULUS only. The counter never holds a value >= MODULUS, even when MODULUS = 2**WIDTH, where natural overflow coincides with the wrap.
- clear_input asserted mid-count or mid-load aborts the operation immediately. No pending state survives.
- Implementation: registers on clk_input with the asynchronous clear. The next-state logic may be behavioural; T flip-flop structure is not mandated.

Test Plan:
- Reset/up wrap (MODULUS=9): hold clear_input low 10 ns, release, enable_input=1, up_input=1 for 10 edges -> contador_output 0..8, then 0. wrap_output high exactly the cycle after the 8->0 edge. terminal_output high while count=8.
- Down wrap: load 2, then enable down for 4 edges -> 2,1,0,8,7. wrap_output pulses once after the 0->8 edge. terminal_output high while count=0.
- Load priority: count=5, assert load_input=1 with load_value_input=3 and enable_input=1 on the same edge -> 3, no increment. terminal_output=0 during load.
- Out-of-range load: load_value_input=12 (MODULUS=9) -> contador_output=0, load_error_output=1. A subsequent valid load of 4 gives 4 with load_error_output still 1. Pulse clear_input low -> load_error_output=0, contador_output=RESET_VALUE.
- Hold and asynchronous clear: enable_input=0 for 5 edges at count=6 -> stays 6. Assert clear_input low between clock edges -> contador_output=0 immediately, before the next edge.
- Cascade/full-range: two instances, WIDTH=4, MODULUS=16, low terminal_output driving high enable_input, count up 40 edges -> combined value 40 (high=2, low=8). Low-stage wrap_output has pulsed exactly twice.
